// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Brief    : Shared constants, state encoding and helpers for the AES read
//            streamer and its buffering.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int         AXI_DATA_W   = 512;
  localparam int         BEAT_BYTES   = 64;
  localparam logic [2:0] AXI_SIZE_64B = 3'd6;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // SLVERR and DECERR both carry bit 1; EXOKAY does not count as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp & 2'b10) != (RESP_OKAY & 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_sync_fifo
// Brief    : Single-clock show-ahead FIFO with occupancy count. The head
//            entry is visible on pop_data whenever empty is low.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage write; the data array itself carries no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + (w_do_push ? c_CNT_W'(1) : '0)
                         - (w_do_pop  ? c_CNT_W'(1) : '0);
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign full     = (r_count == c_CNT_W'(DEPTH));
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/aes_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module   : aes_rd_streamer
// Brief    : AXI4 read master feeding the AES core. Splits a contiguous
//            region into 4KB-safe bursts, reserves FIFO space for each burst
//            before its AR so R is never back-pressured, and streams the
//            beats out on a valid/ready interface.
// Config   : define AES_RD_PERF_EN to add perf_cycles / perf_ar_stall /
//            perf_out_stall counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module aes_rd_streamer
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 128,
  parameter int MAX_BURST  = 64,
  parameter int ID_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [63:0]           cfg_addr,
  input  logic [31:0]           cfg_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_W-1:0]       arid,
  output logic [63:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [AXI_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef AES_RD_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_ar_stall,
  output logic [31:0]           perf_out_stall
`endif
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e          r_state;
  rd_state_e          w_state_nxt;
  logic [63:0]        r_addr;
  logic [31:0]        r_beats_left;
  logic [31:0]        r_total;
  logic [31:0]        r_popped;
  logic [c_CNT_W-1:0] r_reserved;
  logic               r_done;
  logic               r_err;

  logic               w_start_acc;
  logic [6:0]         w_room_4k;
  logic [31:0]        w_len_full;
  logic [7:0]         w_len;
  logic               w_space_ok;
  logic               w_ar_hs;
  logic               w_push;
  logic               w_pop;
  logic               w_final_pop;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [c_CNT_W-1:0] w_fifo_count;
  logic               w_unused;

  assign w_start_acc = cfg_start && (r_state == IDLE);

  // Beats left before the next 4KB boundary (1..64).
  assign w_room_4k = 7'd64 - {1'b0, r_addr[11:6]};

  // Burst length: smallest of the burst cap, remaining beats and 4KB room.
  always_comb begin
    w_len_full = r_beats_left;
    if (w_len_full > 32'(MAX_BURST)) w_len_full = 32'(MAX_BURST);
    if (w_len_full > {25'd0, w_room_4k}) w_len_full = {25'd0, w_room_4k};
  end

  assign w_len      = w_len_full[7:0];
  assign w_space_ok = (32'(FIFO_DEPTH) - 32'(r_reserved)) >= w_len_full;

  // Next state and AXI handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    arvalid     = 1'b0;
    rready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start && (cfg_beats != 32'd0)) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        rready  = 1'b1;
        arvalid = w_space_ok;
        if (w_space_ok && arready && (r_beats_left == w_len_full)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        rready = 1'b1;
        if (w_final_pop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_ar_hs     = arvalid && arready;
  assign w_push      = rvalid && rready;
  assign w_pop       = out_valid && out_ready;
  assign out_last    = out_valid && (r_popped == r_total - 32'd1);
  assign w_final_pop = w_pop && out_last;

  // Transfer bookkeeping: address walk, beat counters, done and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_beats_left <= '0;
      r_total      <= '0;
      r_popped     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_acc) begin
        r_addr       <= {cfg_addr[63:6], 6'b0};
        r_beats_left <= cfg_beats;
        r_total      <= cfg_beats;
        r_popped     <= '0;
        r_err        <= 1'b0;
        r_done       <= (cfg_beats == 32'd0);
      end else begin
        if (w_push && resp_is_err(rresp)) r_err <= 1'b1;
        if (w_ar_hs) begin
          r_addr       <= r_addr + 64'(w_len) * 64'(BEAT_BYTES);
          r_beats_left <= r_beats_left - w_len_full;
        end
        if (w_pop)       r_popped <= r_popped + 32'd1;
        if (w_final_pop) r_done   <= 1'b1;
      end
    end
  end

  // Beats reserved in the FIFO: claimed at AR handshake, released at pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reserved <= '0;
    end else begin
      r_reserved <= r_reserved + (w_ar_hs ? c_CNT_W'(w_len) : '0)
                                - (w_pop   ? c_CNT_W'(1)     : '0);
    end
  end

  aes_sync_fifo #(
    .WIDTH (AXI_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (rdata),
    .pop       (w_pop),
    .pop_data  (out_data),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_fifo_count)
  );

  assign out_valid = !w_fifo_empty;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign arid      = '0;
  assign araddr    = r_addr;
  assign arlen     = w_len - 8'd1;
  assign arsize    = AXI_SIZE_64B;

  // Single outstanding id and in-order data: rid/rlast carry no information here.
  assign w_unused = ^{cfg_addr[5:0], rid, rlast, w_len_full[31:8], w_fifo_full, w_fifo_count};

`ifdef AES_RD_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_ar_stall;
  logic [31:0] r_perf_out_stall;

  // Per-transfer activity counters; cleared on start, frozen once idle.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_perf_cycles    <= '0;
      r_perf_ar_stall  <= '0;
      r_perf_out_stall <= '0;
    end else if (busy) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (arvalid && !arready)     r_perf_ar_stall  <= r_perf_ar_stall + 32'd1;
      if (out_valid && !out_ready) r_perf_out_stall <= r_perf_out_stall + 32'd1;
    end
  end

  assign perf_cycles    = r_perf_cycles;
  assign perf_ar_stall  = r_perf_ar_stall;
  assign perf_out_stall = r_perf_out_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_rd_streamer
// Brief    : Self-checking bench for aes_rd_streamer: AXI read slave model,
//            transaction-level reference model and per-cycle comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_rd_streamer;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } ar_t;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         cfg_start;
  logic [63:0]  cfg_addr;
  logic [31:0]  cfg_beats;
  logic         busy, done, err;
  logic [15:0]  arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid, arready;
  logic [15:0]  rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic [511:0] out_data;
  logic         out_valid, out_ready, out_last;
`ifdef AES_RD_PERF_EN
  logic [31:0]  perf_cycles, perf_ar_stall, perf_out_stall;
`endif

  aes_rd_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_addr  (cfg_addr),
    .cfg_beats (cfg_beats),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef AES_RD_PERF_EN
    ,
    .perf_cycles    (perf_cycles),
    .perf_ar_stall  (perf_ar_stall),
    .perf_out_stall (perf_out_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // reference model state (owned by the comparator process)
  ar_t   exp_ar[$];
  beat_t exp_out[$];
  ar_t   ar_log[$];
  bit    m_busy = 0, m_done = 0, m_err = 0;
  int    m_outst = 0;
  int    done_cnt = 0;
  bit    ar_hold = 0;
  ar_t   hold_ar;

  // handoff from comparator to slave
  bit    ar_fire = 0, r_fire = 0, sl_flush = 0;
  ar_t   ar_cap;

  // slave model state
  ar_t   sl_q[$];
  int    sl_idx = 0;
  int    sl_beat_cnt = 0;
  int    err_beat = -1;
  int    ar_pct = 100, rv_pct = 100, or_pct = 100;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // memory contents: every beat is a function of its own byte address
  function automatic logic [511:0] beat_data(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = a[37:6] ^ 32'(32'h9E37_79B9 * 32'(i + 1));
    return d;
  endfunction

  function automatic int ar_sum();
    int s = 0;
    foreach (ar_log[i]) s += ar_log[i].len;
    return s;
  endfunction

  // Expected transfer: bursts capped at 64 beats, never over a 4KB page.
  task automatic model_start(input logic [63:0] a_in, input int n);
    logic [63:0] a;
    int left, room, len;
    a = {a_in[63:6], 6'b0};
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = beat_data(a + 64'(k) * 64);
      b.last = (k == n - 1);
      exp_out.push_back(b);
    end
    left = n;
    while (left > 0) begin
      ar_t e;
      room = 64 - int'(a[11:6]);
      len  = left;
      if (len > 64)   len = 64;
      if (len > room) len = room;
      e.addr = a;
      e.len  = len;
      exp_ar.push_back(e);
      a    = a + 64'(len) * 64;
      left = left - len;
    end
  endtask

  // Comparator: checks DUT against the model every cycle, then advances the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_done = 0; m_err = 0; m_outst = 0;
        exp_ar.delete(); exp_out.delete();
        ar_hold = 0; ar_fire = 0; r_fire = 0; sl_flush = 1;
      end else begin
        bit busy_n, done_n, err_n;
        busy_n = m_busy; done_n = 0; err_n = m_err;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("err", err, m_err);
        check("rready", rready, m_busy);
        if (done) done_cnt++;
        if (!m_busy) begin
          check("idle_arvalid", arvalid, 0);
          check("idle_out_valid", out_valid, 0);
        end
        ar_fire = 0;
        if (ar_hold) begin
          check("ar_hold_valid", arvalid, 1);
          check("ar_hold_addr", araddr, hold_ar.addr);
          check("ar_hold_len", int'(arlen) + 1, hold_ar.len);
        end
        ar_hold = 0;
        if (arvalid) begin
          if (arready) begin
            ar_cap.addr = araddr;
            ar_cap.len  = int'(arlen) + 1;
            ar_fire = 1;
            ar_log.push_back(ar_cap);
            m_outst += ar_cap.len;
            check("ar_size", arsize, 3'd6);
            check("ar_id", arid, 16'd0);
            check("ar_4k", (int'(araddr[11:6]) + ar_cap.len) <= 64, 1);
            if (exp_ar.size() == 0) fail_now("ar_unexpected");
            else begin
              ar_t e;
              e = exp_ar.pop_front();
              check("ar_addr", araddr, e.addr);
              check("ar_len", ar_cap.len, e.len);
            end
            check("reserve_bound", m_outst <= 128, 1);
          end else begin
            ar_hold = 1;
            hold_ar.addr = araddr;
            hold_ar.len  = int'(arlen) + 1;
          end
        end
        r_fire = rvalid && rready;
        if (r_fire && rresp[1]) err_n = 1;
        if (out_valid) begin
          if (exp_out.size() == 0) fail_now("out_unexpected");
          else begin
            check("out_data", out_data, exp_out[0].data);
            check("out_last", out_last, exp_out[0].last);
            if (out_ready) begin
              beat_t b;
              b = exp_out.pop_front();
              m_outst--;
              if (b.last) begin
                done_n = 1;
                busy_n = 0;
              end
            end
          end
        end
        if (cfg_start && !m_busy) begin
          err_n = 0;
          sl_beat_cnt = 0;
          if (cfg_beats == 0) done_n = 1;
          else begin
            busy_n = 1;
            model_start(cfg_addr, int'(cfg_beats));
          end
        end
        m_busy = busy_n; m_done = done_n; m_err = err_n;
      end
    end
  end

  // AXI read slave plus out_ready driver.
  initial begin
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0; rid = '0; out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (sl_flush) begin
        sl_q.delete();
        sl_idx = 0; rvalid = 0; rlast = 0; sl_flush = 0;
      end else begin
        if (r_fire) begin
          rvalid = 0;
          if (sl_q.size() > 0) begin
            sl_idx++;
            sl_beat_cnt++;
            if (sl_idx >= sl_q[0].len) begin
              sl_q.delete(0);
              sl_idx = 0;
            end
          end
        end
        if (ar_fire) sl_q.push_back(ar_cap);
        if (!rvalid && sl_q.size() > 0 && $urandom_range(99) < rv_pct) begin
          rdata  = beat_data(sl_q[0].addr + 64'(sl_idx) * 64);
          rresp  = (sl_beat_cnt == err_beat) ? 2'b10 : 2'b00;
          rlast  = (sl_idx == sl_q[0].len - 1);
          rvalid = 1;
        end
      end
      arready   = ($urandom_range(99) < ar_pct);
      out_ready = ($urandom_range(99) < or_pct);
    end
  end

  task automatic start_xfer(input logic [63:0] a, input int n);
    @(posedge clk); #1;
    cfg_addr  = a;
    cfg_beats = 32'(n);
    cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (m_busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) fail_now({nm, "_timeout"});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst = 1; cfg_start = 0; cfg_addr = '0; cfg_beats = '0;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_rready", rready, 0);

    // single 4-beat burst
    ar_log.delete();
    d0 = done_cnt;
    start_xfer(64'h1000, 4);
    wait_idle("t1");
    check("t1_ar_count", ar_log.size(), 1);
    if (ar_log.size() >= 1) begin
      check("t1_araddr", ar_log[0].addr, 64'h1000);
      check("t1_arlen", ar_log[0].len - 1, 3);
    end
    check("t1_done_once", done_cnt - d0, 1);

    // 4KB splitting
    ar_pct = 70; rv_pct = 80; or_pct = 70;
    ar_log.delete();
    start_xfer(64'h0FC0, 130);
    wait_idle("t2");
    check("t2_ar_count", ar_log.size(), 4);
    if (ar_log.size() == 4) begin
      check("t2_ar0_addr", ar_log[0].addr, 64'h0FC0);
      check("t2_ar0_len", ar_log[0].len, 1);
      check("t2_ar1_addr", ar_log[1].addr, 64'h1000);
      check("t2_ar1_len", ar_log[1].len, 64);
      check("t2_ar2_addr", ar_log[2].addr, 64'h2000);
      check("t2_ar2_len", ar_log[2].len, 64);
      check("t2_ar3_addr", ar_log[3].addr, 64'h3000);
      check("t2_ar3_len", ar_log[3].len, 1);
    end

    // back-pressure: reservation must stop at FIFO depth
    ar_pct = 100; rv_pct = 100; or_pct = 0;
    ar_log.delete();
    start_xfer(64'h0, 256);
    repeat (200) @(posedge clk);
    #1;
    check("t3_reserved_beats", ar_sum(), 128);
    check("t3_arvalid_low", arvalid, 0);
    check("t3_out_valid", out_valid, 1);
    or_pct = 60;
    wait_idle("t3");
    check("t3_total_beats", ar_sum(), 256);
    check("t3_ar_count", ar_log.size(), 4);

    // error response on beat 2 of 8
    or_pct = 100;
    err_beat = 1;
    start_xfer(64'h8000, 8);
    wait_idle("t4");
    check("t4_err_set", err, 1);
    repeat (3) @(posedge clk);
    #1 check("t4_err_sticky", err, 1);
    err_beat = -1;
    start_xfer(64'h9000, 2);
    check("t4_err_cleared", err, 0);
    wait_idle("t4b");

    // reset in the middle of issuing
    or_pct = 0;
    ar_log.delete();
    start_xfer(64'h0, 512);
    repeat (20) @(posedge clk);
    #1 check("t5_two_bursts", ar_sum(), 128);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    check("t5_busy", busy, 0);
    check("t5_arvalid", arvalid, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_rready", rready, 0);
    or_pct = 80;
    d0 = done_cnt;
    start_xfer(64'h2_0040, 20);
    wait_idle("t5");
    check("t5_done_once", done_cnt - d0, 1);

    // zero-length transfer
    ar_log.delete();
    d0 = done_cnt;
    start_xfer(64'h4000, 0);
    check("t6_busy_zero", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_no_ar", ar_log.size(), 0);

    // start pulse while busy must be ignored
    d0 = done_cnt;
    start_xfer(64'h5000, 40);
    repeat (10) @(posedge clk);
    start_xfer(64'h7000, 3);
    wait_idle("t7");
    check("t7_done_once", done_cnt - d0, 1);

    // randomized transfers
    for (int t = 0; t < 8; t++) begin
      ar_pct = int'($urandom_range(30, 100));
      rv_pct = int'($urandom_range(30, 100));
      or_pct = int'($urandom_range(20, 100));
      d0 = done_cnt;
      start_xfer(64'($urandom_range(0, 32'h3FFFF)), int'($urandom_range(1, 300)));
      wait_idle("rand");
      check("rand_done_once", done_cnt - d0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
